// File: rtl/rgb_error_stat.sv
// rgb_error_stat
// Collects per-frame statistics from the grayscale checker's pass flag:
// pixel/error counts, the first failing pixel position, a sticky error bit
// and a lock indicator that asserts after enough consecutive clean frames.
module rgb_error_stat #(
   parameter int FLAG_LAT    = 1,
   parameter int CNT_W       = 24,
   parameter int X_W         = 12,
   parameter int Y_W         = 12,
   parameter int LOCK_FRAMES = 2
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_de,
   input  logic             I_vs,
   input  logic             I_RGB_true_flag,
   input  logic             I_clr,
   output logic [CNT_W-1:0] O_frame_pix_cnt,
   output logic [CNT_W-1:0] O_frame_err_cnt,
   output logic [X_W-1:0]   O_first_err_x,
   output logic [Y_W-1:0]   O_first_err_y,
   output logic             O_first_err_valid,
   output logic             O_stat_valid,
   output logic             O_err_sticky,
   output logic             O_lock,
   output logic [15:0]      O_frame_cnt
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

   state_t           state;
   logic             de_d, vs_d, de_prev, vs_prev;
   logic [CNT_W-1:0] pix_acc, err_acc, pix_base, err_base;
   logic [X_W-1:0]   x_cnt, x_base, first_x_w;
   logic [Y_W-1:0]   y_cnt, y_base, first_y_w;
   logic             first_valid_w;
   logic [3:0]       clean_cnt, clean_next;
   logic             vs_rise, de_fall, in_frame, frame_close;
   logic             pix, err_pix, first_hit;

   generate
      if (FLAG_LAT == 0) begin : g_no_delay
         assign de_d = I_de;
         assign vs_d = I_vs;
      end else begin : g_delay
         logic [FLAG_LAT-1:0] de_sr, vs_sr;

         // Delay de/vs so they line up with the checker's flag latency
         always_ff @(posedge I_clk or posedge I_rst) begin
            if (I_rst) begin
               de_sr <= '0;
               vs_sr <= '0;
            end else begin
               de_sr[0] <= I_de;
               vs_sr[0] <= I_vs;
               for (int i = 1; i < FLAG_LAT; i++) begin
                  de_sr[i] <= de_sr[i-1];
                  vs_sr[i] <= vs_sr[i-1];
               end
            end
         end

         assign de_d = de_sr[FLAG_LAT-1];
         assign vs_d = vs_sr[FLAG_LAT-1];
      end
   endgenerate

   // Edge detection and next-value bases; a vs_rise restarts everything so
   // that a pixel coinciding with it lands in the new frame at x=0,y=0
   always_comb begin
      vs_rise     = vs_d & ~vs_prev;
      de_fall     = ~de_d & de_prev;
      in_frame    = (state == ACTIVE) | vs_rise;
      frame_close = (state == ACTIVE) & vs_rise;
      pix         = de_d & in_frame;
      err_pix     = pix & ~I_RGB_true_flag;
      pix_base    = vs_rise ? '0 : pix_acc;
      err_base    = vs_rise ? '0 : err_acc;
      x_base      = (vs_rise | de_fall) ? '0 : x_cnt;
      y_base      = vs_rise ? '0 : y_cnt;
      first_hit   = err_pix & (err_base == '0);
      clean_next  = (clean_cnt >= LOCK_N) ? LOCK_N : clean_cnt + 4'd1;
   end

   // Frame FSM plus working accumulators, position counters and first-error capture
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state         <= IDLE;
         de_prev       <= 1'b0;
         vs_prev       <= 1'b0;
         pix_acc       <= '0;
         err_acc       <= '0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         first_x_w     <= '0;
         first_y_w     <= '0;
         first_valid_w <= 1'b0;
      end else begin
         de_prev <= de_d;
         vs_prev <= vs_d;
         if (vs_rise) begin
            state <= ACTIVE;
         end
         if (in_frame) begin
            pix_acc <= pix_base + CNT_W'(pix & ~(&pix_base));
            err_acc <= err_base + CNT_W'(err_pix & ~(&err_base));
            x_cnt   <= x_base + X_W'(pix & ~(&x_base));
            y_cnt   <= y_base + Y_W'(de_fall & ~vs_rise & ~(&y_base));
            if (first_hit) begin
               first_x_w     <= x_base;
               first_y_w     <= y_base;
               first_valid_w <= 1'b1;
            end else if (vs_rise) begin
               first_x_w     <= '0;
               first_y_w     <= '0;
               first_valid_w <= 1'b0;
            end
         end
      end
   end

   // Frame-close publication, lock tracking, sticky error and clear handling
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         O_frame_pix_cnt   <= '0;
         O_frame_err_cnt   <= '0;
         O_first_err_x     <= '0;
         O_first_err_y     <= '0;
         O_first_err_valid <= 1'b0;
         O_stat_valid      <= 1'b0;
         O_err_sticky      <= 1'b0;
         O_lock            <= 1'b0;
         O_frame_cnt       <= '0;
         clean_cnt         <= '0;
      end else begin
         O_stat_valid <= frame_close;
         if (frame_close) begin
            O_frame_pix_cnt   <= pix_acc;
            O_frame_err_cnt   <= err_acc;
            O_first_err_x     <= first_x_w;
            O_first_err_y     <= first_y_w;
            O_first_err_valid <= first_valid_w;
            O_frame_cnt       <= O_frame_cnt + 16'd1;
            if ((err_acc == '0) && (pix_acc != '0)) begin
               clean_cnt <= clean_next;
               O_lock    <= (clean_next == LOCK_N);
            end else begin
               clean_cnt <= '0;
               O_lock    <= 1'b0;
            end
         end
         if (I_clr) begin
            O_first_err_x     <= '0;
            O_first_err_y     <= '0;
            O_first_err_valid <= 1'b0;
            O_frame_cnt       <= '0;
            O_lock            <= 1'b0;
            clean_cnt         <= '0;
         end
         if (err_pix) begin
            O_err_sticky <= 1'b1;
         end else if (I_clr) begin
            O_err_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rgb_error_stat.sv
// tb_rgb_error_stat
// Drives one directed pixel stream into four instances (flag latency 0, 1, 3
// and a narrow-counter instance). Expected frame statistics are queued when a
// frame is closed; per-instance monitors pop and compare on O_stat_valid.
module tb_rgb_error_stat;

   typedef struct {
      int pix;
      int err;
      int fx;
      int fy;
      int fv;
      int lock;
      int fcnt;
   } exp_t;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       de      = 1'b0;
   logic       vs      = 1'b0;
   logic       pass    = 1'b1;
   logic       clr_raw = 1'b0;
   logic [3:1] pass_d  = 3'b111;
   logic [3:1] clr_d   = 3'b000;

   int   tests  = 0;
   int   failed = 0;
   exp_t q1[$], q0[$], q3[$], qs[$];

   logic [23:0] pix1, err1, pix0, err0, pix3, err3;
   logic [3:0]  pixs, errs;
   logic [11:0] fx1, fy1, fx0, fy0, fx3, fy3, fxs, fys;
   logic        fv1, fv0, fv3, fvs, sv1, sv0, sv3, svs;
   logic        sticky1, sticky0, sticky3, stickys;
   logic        lock1, lock0, lock3, locks;
   logic [15:0] fcnt1, fcnt0, fcnt3, fcnts;

   always #5 clk = ~clk;

   // Models the checker's flag latency (and keeps clear aligned with it)
   always @(posedge clk) begin
      pass_d <= {pass_d[2:1], pass};
      clr_d  <= {clr_d[2:1], clr_raw};
   end

   rgb_error_stat #(.FLAG_LAT(1)) u_dut1 (
      .I_clk(clk), .I_rst(rst), .I_de(de), .I_vs(vs), .I_RGB_true_flag(pass_d[1]),
      .I_clr(clr_d[1]), .O_frame_pix_cnt(pix1), .O_frame_err_cnt(err1),
      .O_first_err_x(fx1), .O_first_err_y(fy1), .O_first_err_valid(fv1),
      .O_stat_valid(sv1), .O_err_sticky(sticky1), .O_lock(lock1), .O_frame_cnt(fcnt1));

   rgb_error_stat #(.FLAG_LAT(0)) u_dut0 (
      .I_clk(clk), .I_rst(rst), .I_de(de), .I_vs(vs), .I_RGB_true_flag(pass),
      .I_clr(clr_raw), .O_frame_pix_cnt(pix0), .O_frame_err_cnt(err0),
      .O_first_err_x(fx0), .O_first_err_y(fy0), .O_first_err_valid(fv0),
      .O_stat_valid(sv0), .O_err_sticky(sticky0), .O_lock(lock0), .O_frame_cnt(fcnt0));

   rgb_error_stat #(.FLAG_LAT(3)) u_dut3 (
      .I_clk(clk), .I_rst(rst), .I_de(de), .I_vs(vs), .I_RGB_true_flag(pass_d[3]),
      .I_clr(clr_d[3]), .O_frame_pix_cnt(pix3), .O_frame_err_cnt(err3),
      .O_first_err_x(fx3), .O_first_err_y(fy3), .O_first_err_valid(fv3),
      .O_stat_valid(sv3), .O_err_sticky(sticky3), .O_lock(lock3), .O_frame_cnt(fcnt3));

   rgb_error_stat #(.FLAG_LAT(1), .CNT_W(4)) u_sat (
      .I_clk(clk), .I_rst(rst), .I_de(de), .I_vs(vs), .I_RGB_true_flag(pass_d[1]),
      .I_clr(clr_d[1]), .O_frame_pix_cnt(pixs), .O_frame_err_cnt(errs),
      .O_first_err_x(fxs), .O_first_err_y(fys), .O_first_err_valid(fvs),
      .O_stat_valid(svs), .O_err_sticky(stickys), .O_lock(locks), .O_frame_cnt(fcnts));

   task automatic checkOutput(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkFrame(input string tag, input exp_t e, input int pix, input int err,
                             input int fx, input int fy, input int fv, input int lock,
                             input int fcnt);
      checkOutput({tag, " pix_cnt"}, pix, e.pix);
      checkOutput({tag, " err_cnt"}, err, e.err);
      checkOutput({tag, " first_x"}, fx, e.fx);
      checkOutput({tag, " first_y"}, fy, e.fy);
      checkOutput({tag, " first_valid"}, fv, e.fv);
      checkOutput({tag, " lock"}, lock, e.lock);
      checkOutput({tag, " frame_cnt"}, fcnt, e.fcnt);
   endtask

   task automatic unexpectedStat(input string tag);
      tests++;
      failed++;
      $display("[TB] FAIL %s stat_valid: got 1, expected 0 (nothing queued)", tag);
   endtask

   // Scoreboard entry for one closed frame; the narrow instance saturates at 15
   task automatic pushExp(input int pix, input int err, input int fx, input int fy,
                          input int fv, input int lock, input int fcnt);
      exp_t e;
      e = '{pix, err, fx, fy, fv, lock, fcnt};
      q1.push_back(e);
      q0.push_back(e);
      q3.push_back(e);
      e.pix = (pix > 15) ? 15 : pix;
      e.err = (err > 15) ? 15 : err;
      qs.push_back(e);
   endtask

   // Monitors: one per instance, compare on each stat pulse
   always @(negedge clk) begin : mon_1
      exp_t e;
      if (sv1) begin
         if (q1.size() == 0) unexpectedStat("lat1");
         else begin
            e = q1.pop_front();
            checkFrame("lat1", e, int'(pix1), int'(err1), int'(fx1), int'(fy1),
                       int'(fv1), int'(lock1), int'(fcnt1));
         end
      end
   end

   always @(negedge clk) begin : mon_0
      exp_t e;
      if (sv0) begin
         if (q0.size() == 0) unexpectedStat("lat0");
         else begin
            e = q0.pop_front();
            checkFrame("lat0", e, int'(pix0), int'(err0), int'(fx0), int'(fy0),
                       int'(fv0), int'(lock0), int'(fcnt0));
         end
      end
   end

   always @(negedge clk) begin : mon_3
      exp_t e;
      if (sv3) begin
         if (q3.size() == 0) unexpectedStat("lat3");
         else begin
            e = q3.pop_front();
            checkFrame("lat3", e, int'(pix3), int'(err3), int'(fx3), int'(fy3),
                       int'(fv3), int'(lock3), int'(fcnt3));
         end
      end
   end

   always @(negedge clk) begin : mon_s
      exp_t e;
      if (svs) begin
         if (qs.size() == 0) unexpectedStat("sat");
         else begin
            e = qs.pop_front();
            checkFrame("sat", e, int'(pixs), int'(errs), int'(fxs), int'(fys),
                       int'(fvs), int'(locks), int'(fcnts));
         end
      end
   end

   // One cycle of raw (undelayed) stimulus
   task automatic applyStimulus(input bit d, input bit v, input bit p, input bit c);
      de      = d;
      vs      = v;
      pass    = p;
      clr_raw = c;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic vsPulse(input bit with_clr);
      applyStimulus(1'b0, 1'b1, 1'b1, with_clr);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      idle(2);
   endtask

   // Lines of np pixels; up to two bad pixels (or all bad) and one clear pulse
   task automatic frameBody(input int nl, input int np, input int bla, input int bca,
                            input int blb, input int bcb, input int cl, input int cc,
                            input bit all_bad);
      bit p;
      bit c;
      for (int l = 0; l < nl; l++) begin
         for (int x = 0; x < np; x++) begin
            p = !(all_bad || (l == bla && x == bca) || (l == blb && x == bcb));
            c = (l == cl && x == cc);
            applyStimulus(1'b1, 1'b0, p, c);
         end
         idle(3);
      end
      idle(2);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus sequence
   initial begin
      @(negedge clk);
      idle(3);
      checkOutput("reset pix_cnt", int'(pix1), 0);
      checkOutput("reset err_cnt", int'(err1), 0);
      checkOutput("reset frame_cnt", int'(fcnt1), 0);
      checkOutput("reset lock", int'(lock1), 0);
      checkOutput("reset sticky", int'(sticky1), 0);
      checkOutput("reset stat_valid", int'(sv1), 0);
      rst = 1'b0;
      idle(2);

      frameBody(1, 8, 0, 3, -1, -1, -1, -1, 1'b0);
      idle(6);
      checkOutput("pre-frame sticky lat1", int'(sticky1), 0);
      checkOutput("pre-frame sticky lat3", int'(sticky3), 0);

      vsPulse(1'b0);
      frameBody(4, 8, -1, -1, -1, -1, -1, -1, 1'b0);
      pushExp(32, 0, 0, 0, 0, 0, 1);
      vsPulse(1'b0);
      frameBody(4, 8, -1, -1, -1, -1, -1, -1, 1'b0);
      pushExp(32, 0, 0, 0, 0, 1, 2);
      vsPulse(1'b0);
      frameBody(4, 8, -1, -1, -1, -1, -1, -1, 1'b0);
      pushExp(32, 0, 0, 0, 0, 1, 3);
      vsPulse(1'b0);
      idle(6);
      checkOutput("clean sticky", int'(sticky1), 0);
      checkOutput("clean lock", int'(lock1), 1);

      frameBody(4, 8, 2, 5, 3, 0, -1, -1, 1'b0);
      checkOutput("err sticky lat1", int'(sticky1), 1);
      checkOutput("err sticky lat3", int'(sticky3), 1);
      pushExp(32, 2, 5, 2, 1, 0, 4);
      vsPulse(1'b0);

      frameBody(4, 8, 1, 7, 3, 7, -1, -1, 1'b0);
      pushExp(32, 2, 7, 1, 1, 0, 5);
      vsPulse(1'b0);
      frameBody(4, 8, -1, -1, -1, -1, -1, -1, 1'b0);
      pushExp(32, 0, 0, 0, 0, 0, 6);
      vsPulse(1'b0);
      frameBody(4, 8, -1, -1, -1, -1, -1, -1, 1'b0);
      pushExp(32, 0, 0, 0, 0, 1, 7);
      vsPulse(1'b0);
      idle(6);
      checkOutput("relock lat1", int'(lock1), 1);
      checkOutput("relock lat3", int'(lock3), 1);

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      idle(6);
      checkOutput("clr sticky", int'(sticky1), 0);
      checkOutput("clr lock", int'(lock1), 0);
      checkOutput("clr frame_cnt lat1", int'(fcnt1), 0);
      checkOutput("clr frame_cnt lat3", int'(fcnt3), 0);

      frameBody(4, 8, 0, 2, -1, -1, 0, 2, 1'b0);
      checkOutput("clr+err sticky lat1", int'(sticky1), 1);
      checkOutput("clr+err sticky lat3", int'(sticky3), 1);
      pushExp(32, 1, 2, 0, 1, 0, 1);
      vsPulse(1'b0);
      frameBody(4, 8, -1, -1, -1, -1, -1, -1, 1'b0);
      pushExp(32, 0, 0, 0, 0, 0, 2);
      vsPulse(1'b0);
      frameBody(4, 8, -1, -1, -1, -1, -1, -1, 1'b0);
      pushExp(32, 0, 0, 0, 0, 0, 0);
      vsPulse(1'b1);
      idle(6);
      checkOutput("close+clr sticky", int'(sticky1), 0);

      frameBody(1, 20, -1, -1, -1, -1, -1, -1, 1'b1);
      pushExp(20, 20, 0, 0, 1, 0, 1);
      vsPulse(1'b0);
      idle(6);

      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      idle(4);
      rst = 1'b0;
      idle(2);
      checkOutput("midrst pix_cnt", int'(pix1), 0);
      checkOutput("midrst err_cnt", int'(err1), 0);
      checkOutput("midrst frame_cnt", int'(fcnt1), 0);
      checkOutput("midrst sticky", int'(sticky1), 0);
      checkOutput("midrst first_valid", int'(fv1), 0);
      frameBody(1, 6, -1, -1, -1, -1, -1, -1, 1'b1);
      idle(6);
      checkOutput("post-rst idle sticky lat1", int'(sticky1), 0);
      checkOutput("post-rst idle sticky lat3", int'(sticky3), 0);
      vsPulse(1'b0);
      frameBody(2, 5, 1, 4, -1, -1, -1, -1, 1'b0);
      pushExp(10, 1, 4, 1, 1, 0, 1);
      vsPulse(1'b0);
      idle(10);

      checkOutput("pending lat1", q1.size(), 0);
      checkOutput("pending lat0", q0.size(), 0);
      checkOutput("pending lat3", q3.size(), 0);
      checkOutput("pending sat", qs.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/rgb_error_stat.md
Name: rgb_error_stat

Overview:
Downstream consumer of the per-pixel grayscale check flag. Aligns frame/line timing to the checker's flag latency. Accumulates per-frame error and pixel counts, captures the first failing pixel position, and maintains a sticky error bit and a link-lock indicator. Sits after the RGB grayscale checker on the LVDS receive test path; its outputs feed debug/status registers.

Parameters:
FLAG_LAT, 1, cycles of latency between I_de/I_vs and I_RGB_true_flag; legal 0..4
CNT_W, 24, width of pixel and error accumulators
X_W, 12, width of column position
Y_W, 12, width of line position
LOCK_FRAMES, 2, consecutive clean frames required to assert O_lock; legal 1..15

Ports:
I_clk  in  1  pixel clock
I_rst  in  1  asynchronous active-high reset
I_de  in  1  data enable, undelayed, aligned with the checker's RGB input
I_vs  in  1  frame sync, active high; rising edge marks frame start
I_RGB_true_flag  in  1  1 = pixel grayscale (pass), valid FLAG_LAT cycles after I_de
I_clr  in  1  synchronous clear of sticky/lock/status, single-cycle pulse
O_frame_pix_cnt  out  CNT_W  pixels in last completed frame
O_frame_err_cnt  out  CNT_W  failing pixels in last completed frame
O_first_err_x  out  X_W  column of first failing pixel, last frame
O_first_err_y  out  Y_W  line of first failing pixel, last frame
O_first_err_valid  out  1  last frame contained at least one error
O_stat_valid  out  1  one-cycle pulse when the O_frame_* outputs update
O_err_sticky  out  1  set by any failing pixel, held until I_clr
O_lock  out  1  LOCK_FRAMES consecutive clean, non-empty frames seen
O_frame_cnt  out  16  completed frames since reset/clear, wraps at 0xFFFF->0

Behaviour:
- Reset (async, I_rst high): all outputs 0, all counters/delay lines 0, FSM = IDLE.
- Alignment: I_de and I_vs pass through a FLAG_LAT-stage shift register (de_d, vs_d). FLAG_LAT=0 means no delay. All logic below uses de_d/vs_d with I_RGB_true_flag.
- vs_rise = vs_d & ~vs_d_prev. de_fall = ~de_d & de_d_prev.
- FSM IDLE: ignore pixels; on vs_rise go to ACTIVE and clear accumulators. No stat output for the partial frame before the first vs_rise.
- FSM ACTIVE, per cycle:
  - de_d=1: pix_acc +1; if flag=0, err_acc +1. Both saturate at all-ones, never wrap.
  - x counter: +1 per de_d cycle, saturates at all-ones; cleared on de_fall. y counter: +1 on de_fall, saturates; cleared on vs_rise.
  - First error in frame (err_acc==0 and de_d & ~flag): capture current x,y into working registers, set working first_valid.
  - Error pixel sets O_err_sticky on the next clock edge.
- Frame close on vs_rise in ACTIVE: copy pix_acc, err_acc, working first x/y/valid to outputs; O_stat_valid=1 for exactly that cycle+1 register stage (one-cycle pulse, outputs stable when pulse high); O_frame_cnt +1; accumulators/working regs cleared. A de_d pixel coinciding with vs_rise belongs to the new frame.
- Lock: clean_cnt (4 bits). At frame close: if err_acc==0 and pix_acc>0, clean_cnt +1 saturating at LOCK_FRAMES; else clean_cnt=0. O_lock = (clean_cnt==LOCK_FRAMES), registered, updates with O_stat_valid. Error frame or empty frame drops O_lock immediately at that close.
- I_clr: next edge clears O_err_sticky, O_lock, clean_cnt, O_frame_cnt, O_first_err_*. Does not disturb in-progress accumulators or FSM. I_clr coincident with an error pixel: sticky ends set (error wins). I_clr coincident with frame close: frame close updates counts/first_err, then clear applies to lock/frame_cnt/sticky/first_err (clear wins for those).
- Reset mid-frame: everything returns to IDLE; next vs_rise starts fresh.

Test Plan:
- FLAG_LAT=1, 3 frames of 4 lines x 8 px, flag always 1 -> each close: pix=32, err=0, first_valid=0; O_lock=1 after 2nd close; O_frame_cnt=3; sticky=0.
- Frame 2 has flag=0 at line 2, col 5 and line 3, col 0 -> close: err=2, first_x=5, first_y=2, first_valid=1; O_lock drops to 0; sticky=1 one cycle after first bad pixel.
- Sweep FLAG_LAT 0 and 3 with one bad pixel at last pixel of a line -> err=1 attributed to correct x,y; no error leaks into next line/frame.
- I_clr same cycle as a bad pixel -> sticky=1; I_clr at frame close -> O_frame_cnt=0, O_lock=0, counts still updated.
- CNT_W=4, frame of 20 pixels all failing -> pix=15, err=15 (saturated), no wrap.
- Assert I_rst mid-frame with errors pending -> all outputs 0; pixels before next vs_rise ignored; next frame counts exactly.
